// File: rtl/stack_op_sequencer_pkg.sv
// Shared op and state encodings for the stack op sequencer and its decode-side users.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: op_e (PUSH/POP/CALL/RET), state_e (sequencer FSM), default
// geometry constants and a helper that tells write-type ops from read-type ops.
package stack_op_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEC   = 3'd1,
    ST_WR    = 3'd2,
    ST_RD    = 3'd3,
    ST_INC   = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAULT = 3'd6
  } state_e;

  localparam int unsigned   DEF_DATA_W      = 32;
  localparam int unsigned   DEF_STEP        = 4;
  localparam logic [31:0]   DEF_STACK_BASE  = 32'h0000_1000;
  localparam logic [31:0]   DEF_STACK_LIMIT = 32'h0000_0800;

  // PUSH and CALL pre-decrement ESP and write; POP and RET read and post-increment.
  function automatic logic is_write_op(op_e op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_op_sequencer_if.sv
// Bundles the op request, ESP update, memory handshake and completion signals.
// Latency: n/a (wiring only).
// Backpressure: op_valid/op_ready on the request side, mem_req held until mem_ack.
//
// Modports: slave  = the sequencer (accepts ops, drives ESP/memory/completion)
//           master = decode + ESP register + memory side
interface stack_op_sequencer_if
  import stack_op_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              op_valid;
  logic              op_ready;
  op_e               op_type;
  logic [DATA_W-1:0] op_data;
  logic [DATA_W-1:0] esp;
  logic              esp_wr_en;
  logic [DATA_W-1:0] esp_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              done;
  logic [DATA_W-1:0] result_data;
  logic              pc_load;
  logic              fault;

  modport slave (
    input  op_valid, op_type, op_data, esp, mem_ack, mem_rdata,
    output op_ready, esp_wr_en, esp_wdata, mem_req, mem_we, mem_addr, mem_wdata,
           done, result_data, pc_load, fault
  );

  modport master (
    output op_valid, op_type, op_data, esp, mem_ack, mem_rdata,
    input  op_ready, esp_wr_en, esp_wdata, mem_req, mem_we, mem_addr, mem_wdata,
           done, result_data, pc_load, fault
  );

endinterface

// File: rtl/stack_op_sequencer_addr_calc.sv
// Stack address arithmetic: ESP-STEP, ESP+STEP and the stack-bound compares.
// Latency: combinational.
// Backpressure: none.
//
// Ports: base_i (ESP to work from), dec_o/inc_o (modulo 2^DATA_W),
//        below_limit_o (dec_o < STACK_LIMIT), above_base_o (inc_o > STACK_BASE).
module stack_op_sequencer_addr_calc #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       STEP        = 4,
  parameter logic [DATA_W-1:0] STACK_BASE  = 32'h0000_1000,
  parameter logic [DATA_W-1:0] STACK_LIMIT = 32'h0000_0800
) (
  input  logic [DATA_W-1:0] base_i,
  output logic [DATA_W-1:0] dec_o,
  output logic [DATA_W-1:0] inc_o,
  output logic              below_limit_o,
  output logic              above_base_o
);

  // Plain modulo arithmetic; compares are on the wrapped result.
  assign dec_o         = base_i - DATA_W'(STEP);
  assign inc_o         = base_i + DATA_W'(STEP);
  assign below_limit_o = (dec_o < STACK_LIMIT);
  assign above_base_o  = (inc_o > STACK_BASE);

endmodule

// File: rtl/stack_op_sequencer.sv
// Sequences one PUSH/POP/CALL/RET: ESP update, memory handshake, completion pulse.
// Latency: accept at T, done in T+3 with zero-wait memory; +1 per memory wait cycle.
// Backpressure: op_ready only in IDLE; mem_req and its address/data held until mem_ack.
//
// Ports: clock, reset (sync, active-high); bus (stack_op_sequencer_if.slave) carries
//        the op request, ESP write strobe, memory request/ack and done/pc_load/fault.
// Build option: define STACK_CHECK_EN to turn out-of-range PUSH/CALL/POP/RET into a
//        one-cycle fault pulse with no ESP write or memory access; otherwise fault
//        stays 0 and ESP wraps freely.
module stack_op_sequencer
  import stack_op_sequencer_pkg::*;
#(
  parameter int unsigned       DATA_W      = DEF_DATA_W,
  parameter int unsigned       STEP        = DEF_STEP,
  parameter logic [DATA_W-1:0] STACK_BASE  = DATA_W'(DEF_STACK_BASE),
  parameter logic [DATA_W-1:0] STACK_LIMIT = DATA_W'(DEF_STACK_LIMIT)
) (
  input logic                 clock,
  input logic                 reset,
  stack_op_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] esp_q, esp_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic [DATA_W-1:0] calc_base;
  logic [DATA_W-1:0] esp_dec;
  logic [DATA_W-1:0] esp_inc;
  logic              below_limit;
  logic              above_base;

  logic              op_ready;
  logic              esp_wr_en;
  logic [DATA_W-1:0] esp_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              done;
  logic              pc_load;
  logic              fault;

  // In IDLE the bound check has to judge the incoming ESP before it is latched;
  // in every other state the arithmetic works from the latched copy.
  assign calc_base = (state_q == ST_IDLE) ? bus.esp : esp_q;

  stack_op_sequencer_addr_calc #(
    .DATA_W      (DATA_W),
    .STEP        (STEP),
    .STACK_BASE  (STACK_BASE),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_addr_calc (
    .base_i        (calc_base),
    .dec_o         (esp_dec),
    .inc_o         (esp_inc),
    .below_limit_o (below_limit),
    .above_base_o  (above_base)
  );

`ifndef STACK_CHECK_EN
  logic unused_bound_chk;
  assign unused_bound_chk = below_limit | above_base;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_PUSH;
      data_q   <= '0;
      esp_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      esp_q    <= esp_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    esp_d     = esp_q;
    result_d  = result_q;
    op_ready  = 1'b0;
    esp_wr_en = 1'b0;
    esp_wdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    pc_load   = 1'b0;
    fault     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (bus.op_valid) begin
          op_d   = bus.op_type;
          data_d = bus.op_data;
          esp_d  = bus.esp;
          if (is_write_op(bus.op_type)) begin
`ifdef STACK_CHECK_EN
            state_d = below_limit ? ST_FAULT : ST_DEC;
`else
            state_d = ST_DEC;
`endif
          end else begin
`ifdef STACK_CHECK_EN
            state_d = above_base ? ST_FAULT : ST_RD;
`else
            state_d = ST_RD;
`endif
          end
        end
      end

      ST_DEC: begin
        esp_wr_en = 1'b1;
        esp_wdata = esp_dec;
        state_d   = ST_WR;
      end

      // Write lands at the pre-decremented slot; all mem_* derive from latched
      // state so they cannot move while waiting for the ack.
      ST_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = esp_dec;
        mem_wdata = data_q;
        if (bus.mem_ack) state_d = ST_DONE;
      end

      ST_RD: begin
        mem_req  = 1'b1;
        mem_addr = esp_q;
        if (bus.mem_ack) begin
          result_d = bus.mem_rdata;
          state_d  = ST_INC;
        end
      end

      ST_INC: begin
        esp_wr_en = 1'b1;
        esp_wdata = esp_inc;
        state_d   = ST_DONE;
      end

      ST_DONE: begin
        done    = 1'b1;
        pc_load = (op_q == OP_RET);
        state_d = ST_IDLE;
      end

      ST_FAULT: begin
`ifdef STACK_CHECK_EN
        fault = 1'b1;
`endif
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.op_ready    = op_ready;
  assign bus.esp_wr_en   = esp_wr_en;
  assign bus.esp_wdata   = esp_wdata;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.done        = done;
  assign bus.result_data = result_q;
  assign bus.pc_load     = pc_load;
  assign bus.fault       = fault;

endmodule
